// File: rtl/countdown_timer.sv
// countdown_timer: loadable modulo-N down-counter with one-shot or auto-reload expire pulse
module countdown_timer #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_value,
    input  logic         load_reload,
    input  logic         enable,
    input  logic         cancel,
    output logic         busy,
    output logic [W-1:0] count,
    output logic         expire
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t         state, state_d;
    logic [W-1:0]   count_d, reload_q, reload_d, clamped;
    logic           mode_q, mode_d, expire_d;
    generate
        if (N == (1 << W)) begin : g_pow2
            assign clamped = load_value;
        end else begin : g_clamp
            assign clamped = (load_value > W'(N - 1)) ? W'(N - 1) : load_value;
        end
    endgenerate
    assign busy       = (state == RUN);
    assign load_ready = (state == IDLE) && !rst;
    // next-state: load in IDLE; cancel > pause > decrement > terminal count in RUN
    always_comb begin
        state_d  = state;
        count_d  = count;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (state == IDLE) begin
            if (load_valid && load_ready) begin
                count_d  = clamped;
                reload_d = clamped;
                mode_d   = load_reload;
                state_d  = RUN;
            end
        end else if (cancel) begin
            state_d = IDLE;
            count_d = '0;
        end else if (enable) begin
            if (count != '0) begin
                count_d = count - 1'b1;
            end else begin
                expire_d = 1'b1;
                if (mode_q) count_d = reload_q;
                else        state_d = IDLE;
            end
        end
    end
    // state register; reset aborts any run without an expire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            expire   <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire   <= expire_d;
        end
    end
endmodule
